fifo_wptr_full: RTL and testbench
=================================

# fifo_wptr_full

Write-side control stage for the dual-clock FIFO. It runs in the write clock domain, synchronises the read pointer, and owns the write pointer. It drives the FIFO memory's write address and write enable directly. It also publishes a Gray-coded write pointer for the read-domain empty logic, plus full, almost-full, fill-level and sticky overflow status to the producer.

## Interface

- ADDR_WIDTH, 3, memory address width; FIFO depth is 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- ALMOST_FULL_THRESH, 6, fill level at or above which walmost_full asserts; legal range 1..2**ADDR_WIDTH.

- wclk  input  1  write-domain clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low; clears all state including synchroniser flops.
- winc  input  1  producer write request; a write is accepted only when wfull is 0.
- rq_gray  input  ADDR_WIDTH+1  Gray-coded read pointer from the rclk domain; unsynchronised.
- woverflow_clr  input  1  clears woverflow.
- waddr  output  ADDR_WIDTH  memory write address.
- wen  output  1  memory write enable.
- wptr_gray  output  ADDR_WIDTH+1  registered Gray-coded write pointer, exported to the read domain.
- wfull  output  1  registered full flag.
- walmost_full  output  1  registered almost-full flag.
- wlevel  output  ADDR_WIDTH+1  registered conservative fill count, 0..2**ADDR_WIDTH.
- woverflow  output  1  sticky flag: a write was attempted while full.

## Operation

- Synchroniser: two flops, rq1 <= rq_gray, rq2 <= rq1. Only rq2 is used by downstream logic.
- wen = winc & ~wfull. This is combinational from a registered flag and is the only accept condition.
- wbin is an ADDR_WIDTH+1-bit binary counter.
  - wbin_next = wbin + wen, wrapping modulo 2**(ADDR_WIDTH+1).
  - waddr = wbin[ADDR_WIDTH-1:0].
- wgray_next = (wbin_next >> 1) ^ wbin_next. Register wptr_gray <= wgray_next.
- Full detection:
  - wfull <= (wgray_next == {~rq2[MSB:MSB-1], rq2[MSB-2:0]}).
  - The two MSBs are inverted; the remaining bits are equal.
- Fill level:
  - rbin_s is the Gray-to-binary conversion of rq2.
  - wlevel <= (wbin_next − rbin_s) mod 2**(ADDR_WIDTH+1).
- Almost-full: walmost_full <= (wbin_next − rbin_s) >= ALMOST_FULL_THRESH.
- Overflow, with set taking priority over clear:
  - woverflow <= 1 if (winc & wfull);
  - otherwise 0 if woverflow_clr;
  - otherwise hold.
- Status is pessimistic by design. Reads become visible late, so wfull, walmost_full and wlevel may overstate occupancy. They never understate it.
- Reset values: wbin, rq1, rq2, wptr_gray, wlevel = 0; wfull, walmost_full, woverflow = 0; therefore waddr = 0 and wen = winc.
- Reset mid-operation: all state clears immediately on rst_n falling, independent of wclk. The read domain must be reset in the same window, otherwise pointers are inconsistent.

## Timing

- Write accept:
  - With winc=1 and wfull=0 before edge n, the memory captures the data at edge n.
  - waddr and wptr_gray advance after edge n.
  - The write latency is zero cycles.
- Filling write: the edge that accepts the 2**ADDR_WIDTH-th outstanding word also sets wfull. No extra cycle exists in which a further write could be accepted.
- Read freeing space:
  - rq_gray changes before edge k → rq1 updates at k, rq2 at k+1.
  - wfull, wlevel and walmost_full update at k+2.
  - Total latency is 3 edges, counting the input change.
- woverflow sets at the edge following winc & wfull and stays set until woverflow_clr is sampled with no new overflow.
- Wrap-around: the pointer rolls over from 2**(ADDR_WIDTH+1)−1 to 0 with no discontinuity in the Gray code or the full/level computation.
- wptr_gray changes at most one bit per edge, which keeps it safe to synchronise in the read domain.

## Test plan

- Reset: hold rst_n=0 with random inputs → waddr=0, wptr_gray=0000, wfull=0, walmost_full=0, wlevel=0, woverflow=0. wen follows winc.
- Fill: hold rq_gray=0000 and apply 8 consecutive winc (defaults) →
  - waddr steps 0..7;
  - wptr_gray steps 0001,0011,0010,0110,0111,0101,0100,1100;
  - walmost_full rises after the 6th edge;
  - wfull and wlevel=8 after the 8th edge.
- Overflow: while full, winc=1 for 2 cycles →
  - wen=0 throughout;
  - wptr_gray stays 1100;
  - woverflow=1 after the first edge;
  - woverflow_clr with winc=0 → woverflow=0 next edge;
  - clr together with winc while full → woverflow stays 1.
- Release: from full, set rq_gray=0001 before edge k →
  - wfull=1 through edge k+1;
  - wfull=0 and wlevel=7 after edge k+2;
  - walmost_full stays 1.
- Wrap: 20 writes with rq_gray tracking the write count minus 2 (Gray-encoded) →
  - waddr wraps 7→0;
  - wptr_gray wraps 1000→0000;
  - wfull never asserts;
  - wlevel ≤ 4 throughout.
- Async reset: drop rst_n mid-cycle after 5 writes → all outputs return to reset values before the next wclk edge.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-domain pointer, read-pointer synchroniser and full/level/overflow status for a dual-clock FIFO
module fifo_wptr_full #(
   parameter int ADDR_WIDTH         = 3,
   parameter int ALMOST_FULL_THRESH = 6
) (
   input  logic                  wclk,
   input  logic                  rst_n,
   input  logic                  winc,
   input  logic [ADDR_WIDTH:0]   rq_gray,
   input  logic                  woverflow_clr,
   output logic [ADDR_WIDTH-1:0] waddr,
   output logic                  wen,
   output logic [ADDR_WIDTH:0]   wptr_gray,
   output logic                  wfull,
   output logic                  walmost_full,
   output logic [ADDR_WIDTH:0]   wlevel,
   output logic                  woverflow
);
   localparam logic [ADDR_WIDTH:0] FULL_MASK = {2'b11, {(ADDR_WIDTH-1){1'b0}}};
   localparam logic [ADDR_WIDTH:0] AF_THRESH = ALMOST_FULL_THRESH[ADDR_WIDTH:0];
   logic [ADDR_WIDTH:0] rq1, rq2, wbin, wbin_next, wgray_next, rbin_s, fill_next;
   assign wen        = winc & ~wfull;
   assign waddr      = wbin[ADDR_WIDTH-1:0];
   assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
   assign wgray_next = (wbin_next >> 1) ^ wbin_next;
   assign fill_next  = wbin_next - rbin_s;
   // Gray-to-binary of the synchronised read pointer: each bit is the XOR of itself and all higher bits
   always_comb begin
      rbin_s = '0;
      for (int i = 0; i <= ADDR_WIDTH; i++) rbin_s[i] = ^(rq2 >> i);
   end
   // Two-flop synchroniser for the read pointer crossing in from the read clock
   always_ff @(posedge wclk or negedge rst_n)
      if (!rst_n) {rq1, rq2} <= '0;
      else        {rq1, rq2} <= {rq_gray, rq1};
   // Write pointer and occupancy status; full compares against the read pointer one lap behind
   always_ff @(posedge wclk or negedge rst_n)
      if (!rst_n) begin
         wbin         <= '0;
         wptr_gray    <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
      end else begin
         wbin         <= wbin_next;
         wptr_gray    <= wgray_next;
         wfull        <= wgray_next == (rq2 ^ FULL_MASK);
         walmost_full <= fill_next >= AF_THRESH;
         wlevel       <= fill_next;
      end
   // Sticky overflow: a rejected write sets it, and that wins over a simultaneous clear
   always_ff @(posedge wclk or negedge rst_n)
      if (!rst_n) woverflow <= 1'b0;
      else        woverflow <= (winc & wfull) ? 1'b1 : woverflow_clr ? 1'b0 : woverflow;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: scoreboard bench for the FIFO write-side control stage
module tb_fifo_wptr_full;
   logic       wclk = 1'b0, rst_n = 1'b0, winc = 1'b0, woverflow_clr = 1'b0;
   logic [3:0] rq_gray = '0;
   logic [2:0] waddr;
   logic       wen, wfull, walmost_full, woverflow;
   logic [3:0] wptr_gray, wlevel;
   int         n_checks = 0, n_fail = 0;
   typedef struct packed {
      logic [2:0] waddr;
      logic [3:0] gray;
      logic       full;
      logic       af;
      logic [3:0] lvl;
      logic       ovf;
   } exp_t;
   exp_t       sb[$];
   logic [3:0] m_wbin, m_rq1, m_rq2;
   logic       m_full, m_ovf;
   logic [3:0] gseq [8];

   fifo_wptr_full #(.ADDR_WIDTH(3), .ALMOST_FULL_THRESH(6)) dut (
      .wclk(wclk), .rst_n(rst_n), .winc(winc), .rq_gray(rq_gray),
      .woverflow_clr(woverflow_clr), .waddr(waddr), .wen(wen),
      .wptr_gray(wptr_gray), .wfull(wfull), .walmost_full(walmost_full),
      .wlevel(wlevel), .woverflow(woverflow)
   );

   always #5 wclk = ~wclk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   function automatic logic [3:0] b2g(input logic [3:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [3:0] g2b(input logic [3:0] g);
      logic [3:0] b;
      b[3] = g[3];
      for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   task automatic mreset();
      m_wbin = '0; m_rq1 = '0; m_rq2 = '0; m_full = 1'b0; m_ovf = 1'b0;
      sb.delete();
   endtask

   task automatic step(input logic inc, input logic [3:0] rq, input logic clr);
      exp_t       e;
      logic [3:0] nb;
      logic       mw;
      winc = inc; rq_gray = rq; woverflow_clr = clr;
      #1;
      mw = inc & ~m_full;
      check("wen", wen, mw);
      nb      = m_wbin + {3'b0, mw};
      e.lvl   = nb - g2b(m_rq2);
      e.full  = e.lvl == 4'd8;
      e.af    = e.lvl >= 4'd6;
      e.waddr = nb[2:0];
      e.gray  = b2g(nb);
      e.ovf   = (inc & m_full) ? 1'b1 : clr ? 1'b0 : m_ovf;
      sb.push_back(e);
      m_wbin = nb; m_full = e.full; m_ovf = e.ovf; m_rq2 = m_rq1; m_rq1 = rq;
      @(posedge wclk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         check("waddr", waddr, e.waddr);
         check("wptr_gray", wptr_gray, e.gray);
         check("wfull", wfull, e.full);
         check("walmost_full", walmost_full, e.af);
         check("wlevel", wlevel, e.lvl);
         check("woverflow", woverflow, e.ovf);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_waddr"}, waddr, 0);
      check({tag, "_gray"}, wptr_gray, 0);
      check({tag, "_full"}, wfull, 0);
      check({tag, "_af"}, walmost_full, 0);
      check({tag, "_lvl"}, wlevel, 0);
      check({tag, "_ovf"}, woverflow, 0);
   endtask

   initial begin
      int c;
      gseq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100};
      mreset();
      for (int i = 0; i < 4; i++) begin
         @(posedge wclk);
         #2;
         winc = 1'($urandom); rq_gray = 4'($urandom); woverflow_clr = 1'($urandom);
         #1;
         check_zero("rst");
         check("rst_wen", wen, winc);
      end
      @(posedge wclk);
      #1;
      winc = 1'b0; rq_gray = '0; woverflow_clr = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check("fill_waddr_pre", waddr, i);
         step(1'b1, 4'b0000, 1'b0);
         check("fill_gray_seq", wptr_gray, gseq[i]);
         check("fill_af", walmost_full, i >= 5);
      end
      check("fill_full", wfull, 1);
      check("fill_lvl8", wlevel, 8);
      step(1'b1, 4'b0000, 1'b0);
      check("ovf_set", woverflow, 1);
      step(1'b1, 4'b0000, 1'b0);
      check("ovf_gray_hold", wptr_gray, 4'b1100);
      step(1'b0, 4'b0000, 1'b1);
      check("ovf_clr", woverflow, 0);
      step(1'b1, 4'b0000, 1'b1);
      check("ovf_set_wins", woverflow, 1);
      step(1'b0, 4'b0000, 1'b1);
      step(1'b0, 4'b0001, 1'b0);
      check("rel_k_full", wfull, 1);
      step(1'b0, 4'b0001, 1'b0);
      check("rel_k1_full", wfull, 1);
      step(1'b0, 4'b0001, 1'b0);
      check("rel_k2_full", wfull, 0);
      check("rel_k2_lvl", wlevel, 7);
      check("rel_k2_af", walmost_full, 1);
      for (int i = 0; i < 5; i++) step(1'b1, 4'b0001, 1'b0);
      #3;
      rst_n = 1'b0;
      winc = 1'b0;
      #1;
      check_zero("arst");
      mreset();
      @(posedge wclk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 20; j++) begin
         c = j - 1;
         step(1'b1, c < 0 ? 4'b0000 : b2g(4'(c)), 1'b0);
         check("wrap_nofull", wfull, 0);
         check("wrap_lvl_le4", wlevel <= 4'd4, 1);
         if (j == 7)  check("wrap_waddr0", waddr, 0);
         if (j == 15) check("wrap_gray0", wptr_gray, 0);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
